regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file with a per-register pending-write scoreboard, the successor to the single-read-port core register file. It sits in decode/writeback of the rv32i core: decode reads operands and marks destinations pending; writeback writes results and clears them. Register 0 is hardwired to zero. All state clears on asynchronous reset, and same-cycle writeback-to-read forwarding is optional.

---
 rtl/regfile_mp.sv | 93 +++++++++
 tb/tb_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file with a per-register
// pending-write scoreboard. x0 reads as zero and has no storage; reads are
// combinational with optional same-cycle writeback forwarding.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_sel,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_sel,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_sel,
    output logic [NREGS-1:0]      busy_vec
);

    // Only registers 1..NREGS-1 exist; address 0 and out-of-range addresses
    // never match any index below, so they fall out as "no register".
    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [XLEN-1:0]  regs_d [1:NREGS-1];
    logic [NREGS-1:1] busy_q;
    logic [NREGS-1:1] busy_d;
    logic [NREGS-1:1] wr_hit;
    logic [NREGS-1:1] iss_hit;

    // Per-register decode of writeback/issue and next-state; issue beats a
    // simultaneous writeback because the newer instruction owns the register.
    always_comb begin
        for (int r = 1; r < NREGS; r++) begin
            wr_hit[r]  = wr_en  && (wr_sel  == AW'(r));
            iss_hit[r] = iss_en && (iss_sel == AW'(r));
            regs_d[r]  = wr_hit[r] ? wr_data : regs_q[r];
            busy_d[r]  = iss_hit[r] | (busy_q[r] & ~wr_hit[r]);
        end
    end

    // Register and scoreboard state; reset clears everything without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = {busy_q, 1'b0};

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0]   sel;
            logic [XLEN-1:0] data;
            logic            busy;

            assign sel = rd_sel[gi*AW +: AW];

            // Read mux with optional forwarding; a forwarded write also means
            // the pending bit is being retired this cycle.
            always_comb begin
                data = '0;
                busy = 1'b0;
                for (int r = 1; r < NREGS; r++) begin
                    if (sel == AW'(r)) begin
                        if ((BYPASS != 0) && wr_hit[r]) begin
                            data = wr_data;
                            busy = 1'b0;
                        end else begin
                            data = regs_q[r];
                            busy = busy_q[r];
                        end
                    end
                end
            end

            assign rd_data[gi*XLEN +: XLEN] = data;
            assign rd_busy[gi]              = busy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two instances (24 regs/4 ports/bypass, 32 regs/2 ports/no
// bypass) driven by the same stimulus and compared against an array model.
module tb_regfile_mp;

    logic         clk;
    logic         reset;
    logic [19:0]  rd_sel;
    logic         wr_en;
    logic [4:0]   wr_sel;
    logic [31:0]  wr_data;
    logic         iss_en;
    logic [4:0]   iss_sel;

    logic [127:0] rd_data_a;
    logic [3:0]   rd_busy_a;
    logic [23:0]  busy_vec_a;
    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;
    logic [31:0]  busy_vec_b;

    int compared;
    int mismatched;

    // Reference model: index 0 = instance a, 1 = instance b
    logic [31:0] mem [2][32];
    bit          pend[2][32];
    int          nr  [2] = '{24, 32};
    int          bp  [2] = '{1, 0};

    regfile_mp #(.XLEN(32), .NREGS(24), .NREAD(4), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rd_sel(rd_sel), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .iss_en(iss_en), .iss_sel(iss_sel), .busy_vec(busy_vec_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_sel(rd_sel[9:0]), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .iss_en(iss_en), .iss_sel(iss_sel), .busy_vec(busy_vec_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit valid(int d, int sel);
        return (sel != 0) && (sel < nr[d]);
    endfunction

    function automatic logic [31:0] m_data(int d, int sel);
        if (!valid(d, sel)) return 32'h0;
        if (bp[d] != 0 && wr_en && int'(wr_sel) == sel) return wr_data;
        return mem[d][sel];
    endfunction

    function automatic logic m_busy(int d, int sel);
        if (!valid(d, sel)) return 1'b0;
        if (bp[d] != 0 && wr_en && int'(wr_sel) == sel) return 1'b0;
        return pend[d][sel];
    endfunction

    function automatic logic [31:0] m_vec(int d);
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = pend[d][r];
        return v;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 32; r++) begin
                mem[d][r]  = '0;
                pend[d][r] = 1'b0;
            end
    endtask

    // Clock-edge effect: write, then writeback clears, then issue sets (so
    // issue wins when both target the same register).
    task automatic model_edge();
        if (reset) begin
            model_clear();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            if (wr_en && valid(d, wr_sel)) begin
                mem[d][wr_sel]  = wr_data;
                pend[d][wr_sel] = 1'b0;
            end
            if (iss_en && valid(d, iss_sel)) pend[d][iss_sel] = 1'b1;
        end
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int np = (d == 0) ? 4 : 2;
            for (int p = 0; p < np; p++) begin
                int sel = int'(rd_sel[p*5 +: 5]);
                logic [31:0] od = (d == 0) ? rd_data_a[p*32 +: 32] : rd_data_b[p*32 +: 32];
                logic        ob = (d == 0) ? rd_busy_a[p] : rd_busy_b[p];
                chk($sformatf("d%0d_data%0d_sel%0d", d, p, sel), od, m_data(d, sel));
                chk($sformatf("d%0d_busy%0d_sel%0d", d, p, sel), ob, m_busy(d, sel));
            end
        end
        chk("a_busy_vec", {8'h0, busy_vec_a}, m_vec(0));
        chk("b_busy_vec", busy_vec_b, m_vec(1));
        $display("t=%0t rd_sel=%h wr=%b/%0d/%h iss=%b/%0d vec_a=%h vec_b=%h",
                 $time, rd_sel, wr_en, wr_sel, wr_data, iss_en, iss_sel, busy_vec_a, busy_vec_b);
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        iss_en = 1'b0; iss_sel = '0;
    endtask

    task automatic set_all_rd(int sel);
        for (int p = 0; p < 4; p++) rd_sel[p*5 +: 5] = 5'(sel);
    endtask

    // Settle inputs, check combinational view, then take one clock edge.
    task automatic step();
        #2;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        idle();
        rd_sel = '0;
        reset = 1'b1;
        model_clear();
        #2;
        check_all();
        chk("reset_vec_a", busy_vec_a, 24'h0);
        @(posedge clk);
        model_edge();
        #1;
        reset = 1'b0;

        // Write x5, issue x7, then async reset pulse between edges
        wr_en = 1; wr_sel = 5; wr_data = 32'hDEADBEEF; iss_en = 1; iss_sel = 7;
        set_all_rd(5);
        step();
        idle();
        step();
        chk("x5_written", rd_data_a[31:0], 32'hDEADBEEF);
        chk("x7_pending", busy_vec_a[7], 1'b1);
        reset = 1'b1;
        model_clear();
        #1;
        chk("async_rst_x5", rd_data_a[31:0], 32'h0);
        chk("async_rst_vec_a", busy_vec_a, 24'h0);
        chk("async_rst_vec_b", busy_vec_b, 32'h0);
        check_all();
        reset = 1'b0;
        #1;

        // x0 write and issue are ignored
        wr_en = 1; wr_sel = 0; wr_data = 32'hFFFFFFFF; iss_en = 1; iss_sel = 0;
        set_all_rd(0);
        step();
        idle();
        step();
        chk("x0_read", rd_data_a, 128'h0);
        chk("x0_busy", busy_vec_a[0], 1'b0);

        // Out-of-range on the 24-register instance
        wr_en = 1; wr_sel = 30; wr_data = 32'hCAFEF00D;
        set_all_rd(30);
        step();
        idle();
        step();
        chk("oor_read_a", rd_data_a[31:0], 32'h0);
        chk("inrange_read_b", rd_data_b[31:0], 32'hCAFEF00D);

        // Bypass vs no bypass
        wr_en = 1; wr_sel = 3; wr_data = 32'h11111111;
        set_all_rd(3);
        step();
        wr_data = 32'h12345678;
        #2;
        chk("byp_same_a", rd_data_a[31:0], 32'h12345678);
        chk("nobyp_same_b", rd_data_b[31:0], 32'h11111111);
        step();
        idle();
        step();
        chk("byp_next_a", rd_data_a[31:0], 32'h12345678);
        chk("nobyp_next_b", rd_data_b[31:0], 32'h12345678);

        // Scoreboard lifecycle for x9
        set_all_rd(9);
        iss_en = 1; iss_sel = 9;
        step();
        idle();
        for (int c = 1; c < 4; c++) begin
            step();
            chk($sformatf("x9_busy_c%0d", c), busy_vec_a[9], 1'b1);
        end
        wr_en = 1; wr_sel = 9; wr_data = 32'h99;
        #2;
        chk("x9_wb_rdbusy_a", rd_busy_a[0], 1'b0);
        chk("x9_wb_rdbusy_b", rd_busy_b[0], 1'b1);
        step();
        idle();
        step();
        chk("x9_cleared", busy_vec_a[9], 1'b0);

        // Issue and writeback of x9 in one cycle while busy
        iss_en = 1; iss_sel = 9;
        step();
        iss_en = 1; iss_sel = 9; wr_en = 1; wr_sel = 9; wr_data = 32'h55;
        step();
        idle();
        step();
        chk("x9_issue_wins", busy_vec_a[9], 1'b1);
        chk("x9_data_stored", rd_data_b[31:0], 32'h55);

        // All ports on x12, then pending
        wr_en = 1; wr_sel = 12; wr_data = 32'hA5A5A5A5;
        step();
        idle();
        iss_en = 1; iss_sel = 12;
        set_all_rd(12);
        step();
        idle();
        step();
        chk("x12_all_ports", rd_data_a, {4{32'hA5A5A5A5}});
        chk("x12_all_busy", rd_busy_a, 4'hF);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 4; p++) rd_sel[p*5 +: 5] = 5'($urandom_range(0, 31));
            wr_en   = 1'($urandom_range(0, 1));
            wr_sel  = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            iss_en  = 1'($urandom_range(0, 1));
            iss_sel = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                rd_sel[4:0] = wr_sel;
                iss_sel = wr_sel;
            end
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
